// File: rtl/mips_alu_pkg.sv
// Shared definitions for the toyMIPS ALU-op interface: ALU op codes,
// instruction opcode/funct fields, trap causes and the issue FSM states.
package mips_alu_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD   = 4'b0000,
    ALU_OP_ADDU  = 4'b0001,
    ALU_OP_SUB   = 4'b0010,
    ALU_OP_SUBU  = 4'b0011,
    ALU_OP_AND   = 4'b0100,
    ALU_OP_OR    = 4'b0101,
    ALU_OP_XOR   = 4'b0110,
    ALU_OP_NOR   = 4'b0111,
    ALU_OP_ADDI  = 4'b1000,
    ALU_OP_ADDIU = 4'b1001,
    ALU_OP_SLT   = 4'b1010,
    ALU_OP_SLTU  = 4'b1011,
    ALU_OP_ANDI  = 4'b1100,
    ALU_OP_ORI   = 4'b1101,
    ALU_OP_XORI  = 4'b1110,
    ALU_OP_LUI   = 4'b1111
  } alu_op_e;

  typedef enum logic [5:0] {
    OPC_RTYPE = 6'h00,
    OPC_ADDI  = 6'h08,
    OPC_ADDIU = 6'h09,
    OPC_SLTI  = 6'h0A,
    OPC_SLTIU = 6'h0B,
    OPC_ANDI  = 6'h0C,
    OPC_ORI   = 6'h0D,
    OPC_XORI  = 6'h0E,
    OPC_LUI   = 6'h0F
  } opcode_e;

  typedef enum logic [5:0] {
    FUNCT_ADD  = 6'h20,
    FUNCT_ADDU = 6'h21,
    FUNCT_SUB  = 6'h22,
    FUNCT_SUBU = 6'h23,
    FUNCT_AND  = 6'h24,
    FUNCT_OR   = 6'h25,
    FUNCT_XOR  = 6'h26,
    FUNCT_NOR  = 6'h27,
    FUNCT_SLT  = 6'h2A,
    FUNCT_SLTU = 6'h2B
  } funct_e;

  localparam logic [1:0] TRAP_NONE = 2'b00;
  localparam logic [1:0] TRAP_OVF  = 2'b01;
  localparam logic [1:0] TRAP_ILL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Only the trapping adds/subtracts turn an ALU overflow into a trap.
  function automatic logic op_traps_on_ovf(input logic [3:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) || (op == ALU_OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of one instruction beat into ALU op, operands,
// destination register and an illegal-instruction flag.
module alu_op_decode
  import mips_alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [3:0]  op_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [4:0]  dest_o,
  output logic        illegal_o
);

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [15:0] imm;
  logic        unused_fields;

  assign opc = instr_i[31:26];
  assign fn  = instr_i[5:0];
  assign imm = instr_i[15:0];
  // rs/rt values arrive pre-fetched and shifts are not supported, so the
  // register-index and shamt fields carry no information here.
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  // Map R-type funct or I-type opcode onto the ALU op and operand sources.
  always_comb begin
    op_o      = ALU_OP_ADD;
    a_o       = rs_data_i;
    b_o       = rt_data_i;
    dest_o    = instr_i[15:11];
    illegal_o = 1'b1;
    if (opc == OPC_RTYPE) begin
      case (fn)
        FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
        FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
        FUNCT_SLT, FUNCT_SLTU: begin
          op_o      = fn[3:0];
          illegal_o = 1'b0;
        end
        default: ;
      endcase
    end else if (opc[5:3] == 3'b001) begin
      op_o      = opc[3:0];
      dest_o    = instr_i[20:16];
      illegal_o = 1'b0;
      // Arithmetic/compare immediates sign-extend; logical ones and LUI
      // take the raw 16 bits (the ALU does the LUI shift itself).
      if (opc <= OPC_SLTIU) b_o = {{16{imm[15]}}, imm};
      else                  b_o = {16'h0000, imm};
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller driving the toyMIPS ALU: accepts one decoded
// beat in IDLE, issues registered operands, captures the result in EXEC,
// and holds it in WB until the register file takes it. Overflow on
// trapping ops and illegal instructions raise a one-cycle trap pulse.
module alu_issue_ctrl
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        trap_valid,
  output logic [1:0]  trap_cause
);

  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_dest;
  logic        dec_illegal;

  state_e      state_q;
  logic        in_ready_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_op_q;
  logic [4:0]  dest_q;
  logic        wb_valid_q;
  logic [4:0]  wb_reg_q;
  logic [31:0] wb_data_q;
  logic        trap_valid_q;
  logic [1:0]  trap_cause_q;

  alu_op_decode u_decode (
    .instr_i   (instr),
    .rs_data_i (rs_data),
    .rt_data_i (rt_data),
    .op_o      (dec_op),
    .a_o       (dec_a),
    .b_o       (dec_b),
    .dest_o    (dec_dest),
    .illegal_o (dec_illegal)
  );

  // Issue FSM with all interface outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= ALU_OP_ADD;
      dest_q       <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      trap_valid_q <= 1'b0;
      trap_cause_q <= TRAP_NONE;
    end else begin
      trap_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (dec_illegal) begin
              // Trap without disturbing the operands already on the ALU.
              trap_valid_q <= 1'b1;
              trap_cause_q <= TRAP_ILL;
            end else begin
              alu_a_q    <= dec_a;
              alu_b_q    <= dec_b;
              alu_op_q   <= dec_op;
              dest_q     <= dec_dest;
              in_ready_q <= 1'b0;
              state_q    <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          wb_data_q <= alu_result;
          wb_reg_q  <= dest_q;
          if (alu_overflow && op_traps_on_ovf(alu_op_q)) begin
            trap_valid_q <= 1'b1;
            trap_cause_q <= TRAP_OVF;
            in_ready_q   <= 1'b1;
            state_q      <= ST_IDLE;
          end else if (dest_q == 5'd0) begin
            // Writes to r0 are architecturally discarded.
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            wb_valid_q <= 1'b1;
            state_q    <= ST_WB;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          wb_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign wb_valid   = wb_valid_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;
  assign trap_valid = trap_valid_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        trap_valid;
  logic [1:0]  trap_cause;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural toyMIPS ALU.
  logic [31:0] sum;
  logic [31:0] dif;
  always_comb begin
    sum          = alu_a + alu_b;
    dif          = alu_a - alu_b;
    alu_result   = 32'h0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'h0, 4'h1, 4'h8, 4'h9: begin
        alu_result   = sum;
        alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'h2, 4'h3: begin
        alu_result   = dif;
        alu_overflow = (alu_a[31] != alu_b[31]) && (dif[31] != alu_a[31]);
      end
      4'h4, 4'hC: alu_result = alu_a & alu_b;
      4'h5, 4'hD: alu_result = alu_a | alu_b;
      4'h6, 4'hE: alu_result = alu_a ^ alu_b;
      4'h7:       alu_result = ~(alu_a | alu_b);
      4'hA:       alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      4'hB:       alu_result = {31'h0, alu_a < alu_b};
      default:    alu_result = {alu_b[15:0], 16'h0000};
    endcase
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for exactly one edge, then withdraw it.
  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    instr    = ins;
    rs_data  = rs;
    rt_data  = rt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    instr    = 32'h0;
    rs_data  = 32'h0;
    rt_data  = 32'h0;
    wb_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",   {31'h0, in_ready},   32'h1);
    chk("rst_alu_a",      alu_a,               32'h0);
    chk("rst_alu_b",      alu_b,               32'h0);
    chk("rst_alu_op",     {28'h0, alu_op},     32'h0);
    chk("rst_wb_valid",   {31'h0, wb_valid},   32'h0);
    chk("rst_wb_reg",     {27'h0, wb_reg},     32'h0);
    chk("rst_wb_data",    wb_data,             32'h0);
    chk("rst_trap_valid", {31'h0, trap_valid}, 32'h0);
    chk("rst_trap_cause", {30'h0, trap_cause}, 32'h0);
    rst_n = 1'b1;
    tick();

    // ADD r3 = r1 + r2, 5 + 7
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
    chk("add_op",       {28'h0, alu_op},   32'h0);
    chk("add_a",        alu_a,             32'd5);
    chk("add_b",        alu_b,             32'd7);
    chk("add_ready_e",  {31'h0, in_ready}, 32'h0);
    chk("add_wbv_e",    {31'h0, wb_valid}, 32'h0);
    tick();
    chk("add_wbv",      {31'h0, wb_valid}, 32'h1);
    chk("add_wb_reg",   {27'h0, wb_reg},   32'd3);
    chk("add_wb_data",  wb_data,           32'd12);
    chk("add_ready_w",  {31'h0, in_ready}, 32'h0);
    tick();
    chk("add_wbv_done", {31'h0, wb_valid}, 32'h0);
    chk("add_ready_i",  {31'h0, in_ready}, 32'h1);

    // ADDI overflow traps
    issue(itype(6'h08, 5'd1, 5'd4, 16'h0001), 32'h7FFF_FFFF, 32'h0);
    chk("addi_op",      {28'h0, alu_op},     32'h8);
    chk("addi_b",       alu_b,               32'h1);
    tick();
    chk("addi_trap",    {31'h0, trap_valid}, 32'h1);
    chk("addi_cause",   {30'h0, trap_cause}, 32'h1);
    chk("addi_nowb",    {31'h0, wb_valid},   32'h0);
    chk("addi_ready",   {31'h0, in_ready},   32'h1);
    tick();
    chk("addi_pulse",   {31'h0, trap_valid}, 32'h0);
    chk("addi_hold",    {30'h0, trap_cause}, 32'h1);
    chk("addi_nowb2",   {31'h0, wb_valid},   32'h0);

    // ADDIU same operands: wraps, no trap
    issue(itype(6'h09, 5'd1, 5'd4, 16'h0001), 32'h7FFF_FFFF, 32'h0);
    tick();
    chk("addiu_wbv",    {31'h0, wb_valid},   32'h1);
    chk("addiu_data",   wb_data,             32'h8000_0000);
    chk("addiu_reg",    {27'h0, wb_reg},     32'd4);
    chk("addiu_notrap", {31'h0, trap_valid}, 32'h0);
    tick();

    // SLTI imm=0xFFFF is sign-extended: 5 < -1 is false
    issue(itype(6'h0A, 5'd1, 5'd5, 16'hFFFF), 32'd5, 32'h0);
    chk("slti_b",       alu_b,             32'hFFFF_FFFF);
    chk("slti_op",      {28'h0, alu_op},   32'hA);
    tick();
    chk("slti_data",    wb_data,           32'h0);
    tick();

    // ORI imm=0xFFFF is zero-extended
    issue(itype(6'h0D, 5'd1, 5'd5, 16'hFFFF), 32'h1234_0000, 32'h0);
    chk("ori_b",        alu_b,             32'h0000_FFFF);
    tick();
    chk("ori_data",     wb_data,           32'h1234_FFFF);
    tick();

    // LUI
    issue(itype(6'h0F, 5'd0, 5'd6, 16'hFFFF), 32'h0, 32'h0);
    chk("lui_b",        alu_b,             32'h0000_FFFF);
    chk("lui_op",       {28'h0, alu_op},   32'hF);
    tick();
    chk("lui_data",     wb_data,           32'hFFFF_0000);
    chk("lui_reg",      {27'h0, wb_reg},   32'd6);
    tick();

    // LW is illegal: trap next cycle, stay IDLE, ALU outputs untouched
    issue(itype(6'h23, 5'd1, 5'd5, 16'h0000), 32'hDEAD_BEEF, 32'h0);
    chk("ill_trap",     {31'h0, trap_valid}, 32'h1);
    chk("ill_cause",    {30'h0, trap_cause}, 32'h2);
    chk("ill_ready",    {31'h0, in_ready},   32'h1);
    chk("ill_op_keep",  {28'h0, alu_op},     32'hF);
    chk("ill_b_keep",   alu_b,               32'h0000_FFFF);

    // Next ADD accepted at once, then writeback stalls for 4 cycles
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd10, 32'd20);
    chk("acc_ready",    {31'h0, in_ready},   32'h0);
    chk("acc_a",        alu_a,               32'd10);
    chk("acc_notrap",   {31'h0, trap_valid}, 32'h0);
    wb_ready = 1'b0;
    tick();
    chk("stl_wbv0",     {31'h0, wb_valid},   32'h1);
    chk("stl_data0",    wb_data,             32'd30);
    instr    = rtype(5'd7, 5'd8, 5'd9, 6'h22);
    rs_data  = 32'd99;
    rt_data  = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stl_wbv",    {31'h0, wb_valid},   32'h1);
      chk("stl_data",   wb_data,             32'd30);
      chk("stl_reg",    {27'h0, wb_reg},     32'd3);
      chk("stl_ready",  {31'h0, in_ready},   32'h0);
      chk("stl_a",      alu_a,               32'd10);
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    chk("stl_release",  {31'h0, wb_valid},   32'h0);
    chk("stl_idle",     {31'h0, in_ready},   32'h1);

    // Reset during EXEC of an overflowing ADD: nothing escapes
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h7FFF_FFFF, 32'h1);
    chk("rx_op",        {28'h0, alu_op},     32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rx_ready",     {31'h0, in_ready},   32'h1);
    chk("rx_a",         alu_a,               32'h0);
    chk("rx_b",         alu_b,               32'h0);
    chk("rx_wbv",       {31'h0, wb_valid},   32'h0);
    chk("rx_trap",      {31'h0, trap_valid}, 32'h0);
    chk("rx_cause",     {30'h0, trap_cause}, 32'h0);
    chk("rx_data",      wb_data,             32'h0);
    tick();
    chk("rx_trap2",     {31'h0, trap_valid}, 32'h0);
    chk("rx_wbv2",      {31'h0, wb_valid},   32'h0);

    // R-type with rd=0: result captured but no writeback
    issue(rtype(5'd1, 5'd2, 5'd0, 6'h21), 32'd1, 32'd2);
    tick();
    chk("r0_wbv",       {31'h0, wb_valid},   32'h0);
    chk("r0_ready",     {31'h0, in_ready},   32'h1);
    chk("r0_notrap",    {31'h0, trap_valid}, 32'h0);
    chk("r0_data",      wb_data,             32'd3);
    tick();
    chk("r0_wbv2",      {31'h0, wb_valid},   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/writeback controller on the driving side of the toyMIPS 4-bit ALU-op interface. It accepts one decoded-instruction beat, forms the ALU operands and op code, issues them to the ALU, captures `result`/`overflow`, and hands the result to register writeback through a valid/ready handshake. It raises a precise trap for signed-add/sub overflow and for unsupported instructions. It sits between the operand-fetch stage and the ALU.

## Interface
Parameters:
- none (widths fixed: 32-bit data, 5-bit register index, 4-bit ALU op)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  instruction beat offered
- `in_ready`  out  1  controller can accept a beat
- `instr`  in  32  MIPS instruction word
- `rs_data`  in  32  rs register value, sampled with `instr`
- `rt_data`  in  32  rt register value, sampled with `instr`
- `alu_a`  out  32  ALU operand a (registered)
- `alu_b`  out  32  ALU operand b (registered)
- `alu_op`  out  4  ALU op code (registered)
- `alu_result`  in  32  ALU result (combinational from `alu_*`)
- `alu_overflow`  in  1  ALU signed-overflow flag
- `wb_valid`  out  1  writeback beat valid
- `wb_ready`  in  1  writeback accepts beat
- `wb_reg`  out  5  destination register
- `wb_data`  out  32  destination value
- `trap_valid`  out  1  one-cycle trap pulse
- `trap_cause`  out  2  01 = overflow, 10 = illegal instruction

## Operation
- Decode. `opcode=instr[31:26]`, `funct=instr[5:0]`.
  - R-type (`opcode=0`), `funct` 0x20–0x27, 0x2A, 0x2B: `alu_op=funct[3:0]`, `a=rs_data`, `b=rt_data`, `dest=instr[15:11]`.
  - I-type, `opcode` 0x08–0x0F: `alu_op=opcode[3:0]`, `a=rs_data`, `dest=instr[20:16]`.
  - I-type `b`: `imm` sign-extended for 0x08–0x0B; zero-extended for 0x0C–0x0E; for LUI (0x0F), `b={16'b0,imm}`.
  - Anything else is illegal.
- FSM states: IDLE, EXEC, WB.
  - IDLE: `in_ready=1`. On `in_valid`, register `alu_a`/`alu_b`/`alu_op`/`dest`, then go to EXEC. On an illegal instruction, pulse `trap_valid` with cause 10 and stay in IDLE; the ALU outputs are unchanged.
  - EXEC: capture `alu_result` into `wb_data` and `dest` into `wb_reg`.
    - If `alu_overflow` and `alu_op` ∈ {0000, 0010, 1000}: pulse `trap_valid` with cause 01, go to IDLE, no writeback.
    - Else if `dest==0`: go to IDLE, no writeback.
    - Else go to WB.
  - Overflow is ignored for ADDU/SUBU/ADDIU and all other ops.
  - WB: `wb_valid=1`, and `wb_reg`/`wb_data` are held stable until `wb_ready`. On the handshake cycle go to IDLE.
- No bypassing: `in_ready=0` in EXEC and WB. The next beat is accepted only in IDLE.

## Timing
- Reset values: `in_ready=1`, `alu_a=0`, `alu_b=0`, `alu_op=0000`, `wb_valid=0`, `wb_reg=0`, `wb_data=0`, `trap_valid=0`, `trap_cause=00`, state IDLE.
- Latency: beat accepted at edge N; ALU inputs are valid after N; result captured at N+1; `wb_valid` is high from N+1 to the handshake. Minimum throughput is one instruction per 3 cycles when `wb_ready=1`.
- A trap pulse lasts exactly one cycle: the cycle after the accept edge (illegal) or after the EXEC edge (overflow). `trap_cause` holds its value until the next trap.
- `wb_ready` low in WB stalls indefinitely with outputs stable. `in_valid` is ignored while not in IDLE.
- Reset asserted in any state returns to IDLE on that edge. Any in-flight instruction is discarded with no writeback and no trap.

## Structure
- Shared package `mips_alu_pkg` holds:
  - `ALU_OP_*` 4-bit constants (ADD=0000 … LUI=1111)
  - `OPC_*` and `FUNCT_*` constants
  - `TRAP_OVF`/`TRAP_ILL` codes
  - FSM state enum
- One sub-module, `alu_op_decode`: combinational, mapping `instr`/`rs_data`/`rt_data` to `op`, `a`, `b`, `dest`, `illegal`.
- The FSM and output registers live in the top.

## Test plan
- ADD r3=r1+r2 with `rs=5`, `rt=7`, `wb_ready=1` → `alu_op=0000`, `a=5`, `b=7`; `wb_valid` for one cycle with `wb_reg=3`, `wb_data=12`; `in_ready` low for 2 cycles.
- ADDI `rs=0x7FFFFFFF`, `imm=1` with ALU overflow → `trap_valid` pulse, cause 01, no `wb_valid`. Same operands with ADDIU → `wb_data=0x80000000`, no trap.
- Immediates with `imm=0xFFFF`:
  - SLTI → `b=0xFFFFFFFF`
  - ORI → `b=0x0000FFFF`
  - LUI → `b=0x0000FFFF`, `wb_data=0xFFFF0000`
- `opcode=0x23` (LW) → trap cause 10 in the next cycle; state stays IDLE; the next ADD is accepted immediately.
- WB stall: `wb_ready=0` for 4 cycles → `wb_valid`/`wb_data` stable, `in_ready=0`; `wb_ready=1` → handshake, back to IDLE.
- `rst_n=0` during EXEC → next cycle: all outputs at reset values, no `wb_valid`, no trap. R-type with `rd=0` → no writeback.
